cpu_subsys_bus_arbiter: RTL
===========================

# cpu_subsys_bus_arbiter

Two-master arbiter for the CPU subsystem memory bus. It sits upstream of the host bridge and shares that single valid/ready port between master 0 (CPU core) and master 1 (DMA/debug). Arbitration is round-robin, and a grant is locked for the whole transaction. An optional watchdog force-completes transactions that never see ready.

## Interface
- TIMEOUT_CYCLES, default 256: cycles a granted transaction may wait for ready before forced completion (used only with CPU_SUBSYS_ARB_TIMEOUT_EN); legal range 2..65535.
- sys_clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m0_mem_valid / m1_mem_valid  in  1  master request, held until that master's ready.
- m0_mem_ready / m1_mem_ready  out  1  one-cycle completion pulse to the master.
- m0_mem_addr / m1_mem_addr  in  32  byte address.
- m0_mem_wdata / m1_mem_wdata  in  32  write data.
- m0_mem_we / m1_mem_we  in  1  write enable.
- m0_mem_be / m1_mem_be  in  4  byte enables.
- m0_mem_rdata / m1_mem_rdata  out  32  read data, valid in the ready cycle.
- s_mem_valid  out  1  request to host bridge.
- s_mem_ready  in  1  host bridge completion.
- s_mem_addr / s_mem_wdata / s_mem_we / s_mem_be  out  32/32/1/4  muxed from the granted master.
- s_mem_rdata  in  32  read data from host bridge.
- err_timeout  out  1  sticky flag, set on forced completion; cleared only by reset.

## Operation
- FSM states: IDLE, BUSY0, BUSY1. A 1-bit register last_grant holds the previous winner.
- IDLE:
  - Only m0 valid -> BUSY0. Only m1 valid -> BUSY1.
  - Both valid -> grant the master that is not last_grant (round-robin).
  - Neither valid -> stay in IDLE.
- BUSYx:
  - s_mem_valid = mx_mem_valid. s_mem_addr/wdata/we/be come combinationally from master x.
  - mx_mem_rdata = s_mem_rdata.
  - mx_mem_ready = s_mem_ready & s_mem_valid.
- Completion: in a BUSYx cycle with s_mem_ready=1, the next state is IDLE and last_grant<=x.
- Protocol violation: if mx_mem_valid drops in BUSYx before ready, go to IDLE with no ready pulse and leave last_grant unchanged.
- Non-granted master: ready=0 and rdata=0.
- In IDLE: s_mem_valid=0, and s_mem_addr/wdata/we/be mux master 0 (don't-care downstream).
- Masters and host bridge are already in valid/ready form; no data is registered (no buffering).

## Timing
- Reset values:
  - State IDLE; last_grant=1, so m0 wins the first contention.
  - s_mem_valid=0, m0/m1_mem_ready=0, err_timeout=0, timeout counter 0.
- Arbitration adds exactly one cycle: a request seen in IDLE at edge N drives s_mem_valid from cycle N+1.
- Minimum transaction, with zero-wait downstream: valid at cycle 0, ready pulse at cycle 1.
- Back-to-back: after a completion the FSM passes through IDLE for one cycle. A waiting master therefore gets s_mem_valid two cycles after the other master's ready.
- Simultaneous completion and new request: the new request is sampled in the following IDLE cycle, never in the completion cycle.
- Reset asserted mid-transaction:
  - All state clears immediately (asynchronous); outputs return to reset values without waiting for s_mem_ready.
  - Any downstream response arriving after reset release is ignored because the state is IDLE.

## Configuration
- CPU_SUBSYS_ARB_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUSYx and increments each BUSYx cycle with s_mem_ready=0.
  - When the counter reaches TIMEOUT_CYCLES-1 without ready, the arbiter forces completion in that cycle:
    - mx_mem_ready=1, mx_mem_rdata=32'hDEAD_BEEF, s_mem_valid=0.
    - err_timeout<=1; next state IDLE; last_grant<=x.
  - A real s_mem_ready in that same cycle takes precedence: normal rdata is returned and no error is flagged.
- Not defined: no counter; err_timeout is tied to 0; BUSYx waits indefinitely.

## Test plan
- Single m0 read, zero-wait slave returning 32'h1234_5678: m0 valid at cycle 0 -> s_mem_valid at cycle 1, m0_mem_ready pulse at cycle 1 with rdata 32'h1234_5678.
- Both masters valid from reset, slave ready after 2 wait states, 4 transactions each -> grants alternate m0,m1,m0,m1…; each master sees exactly one ready per request; non-granted master ready stays 0.
- m1 write addr 32'h4000_0010, wdata 32'hCAFE_F00D, be 4'b0011 while m0 idle -> s_mem_addr/wdata/we/be match exactly for every BUSY1 cycle.
- rst_n pulsed low during BUSY0 with slave stalled -> s_mem_valid and m0_mem_ready go 0 immediately; after release a new m1 request is granted first cycle-wise per reset last_grant=1 rule (m0 wins only if both valid).
- With CPU_SUBSYS_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never ready -> m0_mem_ready pulses in 8th BUSY0 cycle with rdata 32'hDEAD_BEEF, err_timeout sticks at 1; without the macro, ready never asserts over 1000 cycles.
- Master 0 drops valid in BUSY0 before ready -> FSM returns to IDLE next cycle, no ready pulse; pending m0 request still wins next contention.

Source files
------------

// File: rtl/cpu_subsys_bus_arbiter.sv
// rtl/cpu_subsys_bus_arbiter.sv - two-master round-robin memory bus arbiter with transaction-locked grant
// Optional ready watchdog enabled by defining CPU_SUBSYS_ARB_TIMEOUT_EN.
module cpu_subsys_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        sys_clk,
   input  logic        rst_n,
   input  logic        m0_mem_valid,
   output logic        m0_mem_ready,
   input  logic [31:0] m0_mem_addr,
   input  logic [31:0] m0_mem_wdata,
   input  logic        m0_mem_we,
   input  logic [3:0]  m0_mem_be,
   output logic [31:0] m0_mem_rdata,
   input  logic        m1_mem_valid,
   output logic        m1_mem_ready,
   input  logic [31:0] m1_mem_addr,
   input  logic [31:0] m1_mem_wdata,
   input  logic        m1_mem_we,
   input  logic [3:0]  m1_mem_be,
   output logic [31:0] m1_mem_rdata,
   output logic        s_mem_valid,
   input  logic        s_mem_ready,
   output logic [31:0] s_mem_addr,
   output logic [31:0] s_mem_wdata,
   output logic        s_mem_we,
   output logic [3:0]  s_mem_be,
   input  logic [31:0] s_mem_rdata,
   output logic        err_timeout
);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2} state_t;

   localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

   state_t state, state_nxt;
   logic   last_grant, last_grant_nxt;
   logic   gnt1;
   logic   mx_valid;
   logic   timeout_hit;

   if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be within 2..65535");
   end

   assign gnt1     = (state == BUSY1);
   assign mx_valid = gnt1 ? m1_mem_valid : m0_mem_valid;

`ifdef CPU_SUBSYS_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt;
   logic        err_q;

   // A real ready in the same cycle wins over the watchdog.
   assign timeout_hit = (state != IDLE) && mx_valid && !s_mem_ready && (wait_cnt == TIMEOUT_LAST);

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         if ((state != IDLE) && (state_nxt != IDLE))
            wait_cnt <= wait_cnt + 16'd1;
         else
            wait_cnt <= '0;
         if (timeout_hit)
            err_q <= 1'b1;
      end
   end

   assign err_timeout = err_q;
`else
   assign timeout_hit = 1'b0;
   assign err_timeout = 1'b0;
`endif

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      s_mem_valid    = 1'b0;
      s_mem_addr     = gnt1 ? m1_mem_addr  : m0_mem_addr;
      s_mem_wdata    = gnt1 ? m1_mem_wdata : m0_mem_wdata;
      s_mem_we       = gnt1 ? m1_mem_we    : m0_mem_we;
      s_mem_be       = gnt1 ? m1_mem_be    : m0_mem_be;
      m0_mem_ready   = 1'b0;
      m1_mem_ready   = 1'b0;
      m0_mem_rdata   = '0;
      m1_mem_rdata   = '0;
      case (state)
         IDLE: begin
            if (m0_mem_valid && m1_mem_valid)
               state_nxt = last_grant ? BUSY0 : BUSY1;
            else if (m0_mem_valid)
               state_nxt = BUSY0;
            else if (m1_mem_valid)
               state_nxt = BUSY1;
         end
         BUSY0, BUSY1: begin
            s_mem_valid = mx_valid && !timeout_hit;
            if (gnt1) begin
               m1_mem_rdata = timeout_hit ? TIMEOUT_RDATA : s_mem_rdata;
               m1_mem_ready = (s_mem_ready && s_mem_valid) || timeout_hit;
            end else begin
               m0_mem_rdata = timeout_hit ? TIMEOUT_RDATA : s_mem_rdata;
               m0_mem_ready = (s_mem_ready && s_mem_valid) || timeout_hit;
            end
            // A master abandoning its request releases the bus without earning its turn.
            if (!mx_valid) begin
               state_nxt = IDLE;
            end else if (s_mem_ready || timeout_hit) begin
               state_nxt      = IDLE;
               last_grant_nxt = gnt1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule
